// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction cache frame layout and FSM states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam int unsigned ICACHE_SETS = 16;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_t;

   // Tag field is wide enough for any legal index width; unused upper bits stay zero.
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      word_t       data;
   } icache_frame_t;

endpackage

// File: rtl/icache_ctrl.sv
// Instruction cache controller: IDLE/FILL sequencing, miss address latch and
// hit/miss performance counters.
import cpu_types_pkg::*;

module icache_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic             halt,
   input  logic             lookup_hit,
   input  logic [29:0]      word_addr,
   input  logic             iwait,
   output logic             ihit,
   output logic             iren,
   output word_t            iaddr,
   output logic             fill_we,
   output word_t            miss_addr,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   icache_state_t state, state_next;
   logic          go;
   logic          miss_start;

   always_comb begin
      state_next = state;
      go         = req & ~halt;
      ihit       = 1'b0;
      iren       = 1'b0;
      fill_we    = 1'b0;
      miss_start = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               if (lookup_hit) begin
                  ihit = 1'b1;
               end else begin
                  miss_start = 1'b1;
                  state_next = FILL;
               end
            end
         end
         FILL: begin
            // The fill runs to completion even if the request drops or the address moves.
            iren = 1'b1;
            if (!iwait) begin
               fill_we    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign iaddr = iren ? miss_addr : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         miss_addr <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         state <= state_next;
         if (miss_start) begin
            miss_addr <= {word_addr, 2'b00};
         end
         if (ihit && !halt) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
         end
         if (miss_start && !halt) begin
            miss_cnt <= miss_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: frame array and hit compare, with
// single-word fills sequenced by icache_ctrl.
import cpu_types_pkg::*;

module icache_direct #(
   parameter int unsigned ISETS = ICACHE_SETS,
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             imemREN,
   input  logic [31:0]      imemaddr,
   output logic             ihit,
   output logic [31:0]      imemload,
   output logic             iREN,
   output logic [31:0]      iaddr,
   input  logic             iwait,
   input  logic [31:0]      iload,
   input  logic             halt,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int unsigned IDX_W = $clog2(ISETS);

   icache_frame_t    frames [ISETS];
   icache_frame_t    rd_frame;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic [29:0]      rd_tag;
   logic [29:0]      wr_tag;
   logic             lookup_hit;
   logic             fill_we;
   word_t            miss_addr;
   logic             unused_byte_offset;

   assign unused_byte_offset = ^imemaddr[1:0];

   assign rd_idx     = imemaddr[IDX_W+1:2];
   assign rd_tag     = 30'(imemaddr[31:IDX_W+2]);
   assign rd_frame   = frames[rd_idx];
   assign lookup_hit = rd_frame.valid && (rd_frame.tag == rd_tag);
   assign imemload   = ihit ? rd_frame.data : '0;

   assign wr_idx = miss_addr[IDX_W+1:2];
   assign wr_tag = 30'(miss_addr[31:IDX_W+2]);

   // Only valid bits are cleared on reset; tag and data are qualified by valid.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int unsigned i = 0; i < ISETS; i++) begin
            frames[i].valid <= 1'b0;
         end
      end else if (fill_we) begin
         frames[wr_idx] <= '{valid: 1'b1, tag: wr_tag, data: iload};
      end
   end

   icache_ctrl #(
      .CNT_W(CNT_W)
   ) u_ctrl (
      .clk        (CLK),
      .rst_n      (nRST),
      .req        (imemREN),
      .halt       (halt),
      .lookup_hit (lookup_hit),
      .word_addr  (imemaddr[31:2]),
      .iwait      (iwait),
      .ihit       (ihit),
      .iren       (iREN),
      .iaddr      (iaddr),
      .fill_we    (fill_we),
      .miss_addr  (miss_addr),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: stimulus queues expected hit data, a
// monitor pops and compares on every ihit cycle; a model memory answers fills.
module tb_icache_direct;

   logic        CLK;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        halt;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] sb [$];
   logic [31:0] mem [logic [31:0]];
   int unsigned wait_cycles = 0;
   int unsigned exp_hit = 0;
   int unsigned exp_miss = 0;

   icache_direct #(
      .ISETS(16),
      .CNT_W(32)
   ) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .halt     (halt),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Model memory: iwait high for wait_cycles cycles of each fill, then data.
   initial begin
      int unsigned busy;
      busy  = 0;
      iwait = 1'b1;
      iload = '0;
      forever begin
         @(posedge CLK);
         #2;
         if (iREN) begin
            if (busy > 0) begin
               iwait = 1'b1;
               busy--;
            end else begin
               iwait = 1'b0;
               iload = mem.exists(iaddr) ? mem[iaddr] : ~iaddr;
            end
         end else begin
            iwait = 1'b1;
            iload = '0;
            busy  = wait_cycles;
         end
      end
   end

   // Monitor: every ihit cycle must match the oldest queued expectation.
   initial begin
      logic [31:0] exp;
      forever begin
         @(negedge CLK);
         if (ihit) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_hit actual=ihit 1 data 0x%08h required=ihit 0", imemload);
            end else begin
               exp = sb.pop_front();
               check("hit_data", imemload, exp);
            end
         end else begin
            check("load_when_no_hit", imemload, 32'h0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   // One fetch: expects exactly one hit cycle after a fill of 1+waits cycles (or none).
   task automatic access(input logic [31:0] a, input logic [31:0] d,
                         input int unsigned waits, input bit miss);
      int unsigned fills;
      int unsigned bad_addr;
      bit          got;
      fills    = 0;
      bad_addr = 0;
      got      = 1'b0;
      mem[{a[31:2], 2'b00}] = d;
      wait_cycles = waits;
      imemaddr    = a;
      imemREN     = 1'b1;
      sb.push_back(d);
      if (miss) exp_miss++;
      exp_hit++;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge CLK);
         if (ihit) begin
            got = 1'b1;
         end else if (iREN) begin
            fills++;
            if (iaddr !== {a[31:2], 2'b00}) bad_addr++;
         end
      end
      check("hit_seen", 32'(got), 32'd1);
      check("fill_len", fills, miss ? waits + 1 : 0);
      check("fill_iaddr_bad", bad_addr, 32'd0);
      @(posedge CLK);
      #1;
      imemREN = 1'b0;
      check("hit_cnt", hit_cnt, exp_hit);
      check("miss_cnt", miss_cnt, exp_miss);
   endtask

   initial begin
      int unsigned n10;
      int unsigned n20;
      int unsigned nbad;
      bit          got;

      // Reset with a pending request
      nRST     = 1'b0;
      halt     = 1'b0;
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0040;
      mem[32'h0000_0040] = 32'h1234_5678;
      sb.push_back(32'h1234_5678);
      repeat (3) @(negedge CLK);
      check("reset_ihit", 32'(ihit), 32'd0);
      check("reset_iren", 32'(iREN), 32'd0);
      check("reset_iaddr", iaddr, 32'h0);
      check("reset_hit_cnt", hit_cnt, 32'd0);
      check("reset_miss_cnt", miss_cnt, 32'd0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check("iren_after_reset", 32'(iREN), 32'd1);
      check("iaddr_after_reset", iaddr, 32'h0000_0040);
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         if (ihit) got = 1'b1;
         else @(negedge CLK);
      end
      check("reset_fill_hit_seen", 32'(got), 32'd1);
      @(posedge CLK);
      #1;
      imemREN  = 1'b0;
      exp_hit  = 1;
      exp_miss = 1;
      check("hit_cnt", hit_cnt, exp_hit);
      check("miss_cnt", miss_cnt, exp_miss);

      // Cold miss with three wait cycles, then repeated hits
      access(32'h0000_0004, 32'h2001_0005, 3, 1'b1);
      access(32'h0000_0004, 32'h2001_0005, 0, 1'b0);
      access(32'h0000_0006, 32'h2001_0005, 0, 1'b0);

      // Conflict on index 0
      access(32'h0000_0000, 32'hAAAA_0001, 0, 1'b1);
      access(32'h0000_0040, 32'hBBBB_0002, 1, 1'b1);
      access(32'h0000_0000, 32'hAAAA_0001, 0, 1'b1);
      access(32'h0000_0000, 32'hAAAA_0001, 0, 1'b0);

      // Redirect mid-fill: 0x10 fill completes, then 0x20 misses afresh
      mem[32'h0000_0010] = 32'hCCCC_0010;
      mem[32'h0000_0020] = 32'hDDDD_0020;
      wait_cycles = 2;
      imemaddr    = 32'h0000_0010;
      imemREN     = 1'b1;
      @(posedge CLK);
      #1;
      imemaddr = 32'h0000_0020;
      sb.push_back(32'hDDDD_0020);
      n10  = 0;
      n20  = 0;
      nbad = 0;
      got  = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge CLK);
         if (ihit) got = 1'b1;
         else if (iREN) begin
            if (iaddr === 32'h0000_0010) n10++;
            else if (iaddr === 32'h0000_0020) n20++;
            else nbad++;
         end
      end
      check("redirect_hit_seen", 32'(got), 32'd1);
      check("redirect_fill_0x10", n10, 32'd3);
      check("redirect_fill_0x20", n20, 32'd3);
      check("redirect_fill_other", nbad, 32'd0);
      @(posedge CLK);
      #1;
      imemREN = 1'b0;
      exp_miss += 2;
      exp_hit++;
      check("hit_cnt", hit_cnt, exp_hit);
      check("miss_cnt", miss_cnt, exp_miss);
      access(32'h0000_0010, 32'hCCCC_0010, 0, 1'b0);
      access(32'h0000_0020, 32'hDDDD_0020, 0, 1'b0);

      // Reset during a stalled fill abandons it
      mem[32'h0000_0030] = 32'hEEEE_0030;
      wait_cycles = 5;
      imemaddr    = 32'h0000_0030;
      imemREN     = 1'b1;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      check("fill_before_reset", 32'(iREN), 32'd1);
      nRST = 1'b0;
      #1;
      check("iren_in_reset", 32'(iREN), 32'd0);
      check("hit_cnt_in_reset", hit_cnt, 32'd0);
      check("miss_cnt_in_reset", miss_cnt, 32'd0);
      exp_hit  = 0;
      exp_miss = 0;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      access(32'h0000_0030, 32'hEEEE_0030, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         access(32'h0000_0030, 32'hEEEE_0030, 0, 1'b0);
      end

      // Halt: no new misses, no hits, counters frozen
      halt     = 1'b1;
      mem[32'h0000_0050] = 32'hFFFF_0050;
      imemaddr = 32'h0000_0050;
      imemREN  = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         check("halt_iren", 32'(iREN), 32'd0);
      end
      @(posedge CLK);
      #1;
      imemaddr = 32'h0000_0030;
      @(negedge CLK);
      check("halt_ihit", 32'(ihit), 32'd0);
      @(posedge CLK);
      #1;
      check("halt_hit_cnt", hit_cnt, 32'd6);
      check("halt_miss_cnt", miss_cnt, 32'd1);
      halt = 1'b0;
      access(32'h0000_0050, 32'hFFFF_0050, 1, 1'b1);

      repeat (3) @(negedge CLK);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
